// File: rtl/rs_issue_sched.sv
// rs_issue_sched: grants at most one ready add or mul/div RS entry per cycle to the shared dispatch port.
// Build option RS_AGE_PRIO_EN: oldest-first selection by ROB distance from head instead of round-robin.
module rs_issue_sched #(
  parameter int N_ADD      = 3,
  parameter int N_MUL      = 3,
  parameter int ROB_W      = 3,
  parameter int MUL_LAT    = 4,
  parameter int DIV_LAT    = 8,
  parameter int STARVE_MAX = 4
) (
  input  logic                     clk1,
  input  logic                     rst,
  input  logic                     flush,
  input  logic [N_ADD-1:0]         add_rdy,
  input  logic [N_MUL-1:0]         mul_rdy,
  input  logic [N_MUL-1:0]         mul_is_div,
  input  logic [N_ADD*ROB_W-1:0]   add_rob,
  input  logic [N_MUL*ROB_W-1:0]   mul_rob,
  input  logic [ROB_W-1:0]         rob_head,
  input  logic                     add_fu_free,
  output logic                     iss_valid,
  output logic                     iss_unit,
  output logic [1:0]               iss_idx,
  output logic [N_ADD-1:0]         add_clr,
  output logic [N_MUL-1:0]         mul_clr,
  output logic                     mul_busy
);
  localparam int MAXL = (DIV_LAT > MUL_LAT) ? DIV_LAT : MUL_LAT;
  localparam int CW   = $clog2(MAXL + 1);
  localparam int SW   = $clog2(STARVE_MAX + 1);

  logic [N_ADD-1:0] pend_add;
  logic [N_MUL-1:0] pend_mul;
  logic [SW-1:0]    scnt;
  logic [CW-1:0]    mcnt;
  logic             mul_gnt_q;

  logic [N_ADD-1:0] add_elig, add_oh;
  logic [N_MUL-1:0] mul_elig, mul_oh;
  logic [1:0]       add_sel, mul_sel;
  logic             add_any, mul_any, starve, gnt_add, gnt_mul;

`ifdef RS_AGE_PRIO_EN
  function automatic logic [1:0] age_pick(input logic [3:0] el, input logic [4*ROB_W-1:0] robs,
                                          input logic [ROB_W-1:0] head);
    logic [1:0]       pick  = 2'd0;
    logic [ROB_W-1:0] best  = '1;
    logic             found = 1'b0;
    logic [ROB_W-1:0] key;
    for (int i = 0; i < 4; i++) begin
      key = robs[i*ROB_W +: ROB_W] - head;
      // Strict compare keeps the lower index on equal age.
      if (el[i] && (!found || key < best)) begin
        pick  = 2'(i);
        best  = key;
        found = 1'b1;
      end
    end
    return pick;
  endfunction

  assign add_sel = age_pick(4'(add_elig), (4*ROB_W)'(add_rob), rob_head);
  assign mul_sel = age_pick(4'(mul_elig), (4*ROB_W)'(mul_rob), rob_head);
`else
  logic [1:0] ptr_add, ptr_mul;
  logic       unused_rob;

  function automatic logic [1:0] rr_pick(input logic [3:0] el, input logic [1:0] ptr, input int n);
    logic [1:0] pick = 2'd0;
    // Walk offsets from far to near so the nearest eligible entry past ptr wins.
    for (int off = 3; off >= 0; off--) begin
      int k;
      k = (int'(ptr) + off) % n;
      if (off < n && el[k[1:0]]) pick = k[1:0];
    end
    return pick;
  endfunction

  assign unused_rob = ^{add_rob, mul_rob, rob_head};
  assign add_sel    = rr_pick(4'(add_elig), ptr_add, N_ADD);
  assign mul_sel    = rr_pick(4'(mul_elig), ptr_mul, N_MUL);

  always_ff @(posedge clk1) begin
    if (rst) begin
      ptr_add <= 2'd0;
      ptr_mul <= 2'd0;
    end else begin
      if (gnt_add) ptr_add <= (add_sel == 2'(N_ADD - 1)) ? 2'd0 : add_sel + 2'd1;
      if (gnt_mul) ptr_mul <= (mul_sel == 2'(N_MUL - 1)) ? 2'd0 : mul_sel + 2'd1;
    end
  end
`endif

  // p0: eligibility and class arbitration from current inputs and state
  always_comb begin
    add_elig = add_rdy & ~pend_add & {N_ADD{add_fu_free}};
    mul_elig = mul_rdy & ~pend_mul & {N_MUL{mcnt == '0}};
    add_any  = |add_elig;
    mul_any  = |mul_elig;
    starve   = mul_any && (scnt == SW'(STARVE_MAX));
    gnt_mul  = !flush && mul_any && (starve || !add_any);
    gnt_add  = !flush && add_any && !starve;
    add_oh   = N_ADD'(1) << add_sel;
    mul_oh   = N_MUL'(1) << mul_sel;
  end

  // p1: registered issue decision, pend masks and unit occupancy
  always_ff @(posedge clk1) begin
    if (rst) begin
      iss_valid <= 1'b0;
      iss_unit  <= 1'b0;
      iss_idx   <= 2'd0;
      add_clr   <= '0;
      mul_clr   <= '0;
      pend_add  <= '0;
      pend_mul  <= '0;
      scnt      <= '0;
      mcnt      <= '0;
      mul_gnt_q <= 1'b0;
    end else begin
      iss_valid <= gnt_add | gnt_mul;
      iss_unit  <= gnt_mul;
      iss_idx   <= gnt_mul ? mul_sel : (gnt_add ? add_sel : 2'd0);
      add_clr   <= gnt_add ? add_oh : '0;
      mul_clr   <= gnt_mul ? mul_oh : '0;
      pend_add  <= gnt_add ? add_oh : '0;
      pend_mul  <= gnt_mul ? mul_oh : '0;
      mul_gnt_q <= gnt_mul;
      if (gnt_mul) mcnt <= mul_is_div[mul_sel] ? CW'(DIV_LAT - 1) : CW'(MUL_LAT - 1);
      else if (mcnt != '0) mcnt <= mcnt - CW'(1);
      if (flush || gnt_mul || !mul_any) scnt <= '0;
      else if (gnt_add && scnt != SW'(STARVE_MAX)) scnt <= scnt + SW'(1);
    end
  end

  assign mul_busy = (mcnt != '0) | mul_gnt_q;
endmodule

// File: tb/tb_rs_issue_sched.sv
// Self-checking bench for rs_issue_sched against a cycle-level behavioural model of the issue rules.
module tb_rs_issue_sched;
  localparam int NA = 3, NM = 3, RW = 3, ML = 4, DL = 8, SM = 4;

  logic clk1 = 1'b0;
  logic rst, flush, add_fu_free;
  logic [2:0] add_rdy, mul_rdy, mul_is_div, rob_head;
  logic [8:0] add_rob, mul_rob;
  logic iss_valid, iss_unit, mul_busy;
  logic [1:0] iss_idx;
  logic [2:0] add_clr, mul_clr;

  rs_issue_sched #(.N_ADD(NA), .N_MUL(NM), .ROB_W(RW), .MUL_LAT(ML), .DIV_LAT(DL), .STARVE_MAX(SM)) dut (
    .clk1(clk1), .rst(rst), .flush(flush), .add_rdy(add_rdy), .mul_rdy(mul_rdy),
    .mul_is_div(mul_is_div), .add_rob(add_rob), .mul_rob(mul_rob), .rob_head(rob_head),
    .add_fu_free(add_fu_free), .iss_valid(iss_valid), .iss_unit(iss_unit), .iss_idx(iss_idx),
    .add_clr(add_clr), .mul_clr(mul_clr), .mul_busy(mul_busy));

  always #5 clk1 = ~clk1;

  int checks = 0, errors = 0;
  int m_ptr_a, m_ptr_m, m_lost, m_free_at, m_last_mg, m_pu, m_pi;
  bit m_pv;
  int edge_n = 0;
  logic [10:0] exp_o;
  wire  [10:0] obs = {iss_valid, iss_unit, iss_idx, add_clr, mul_clr, mul_busy};

  function automatic int pick(input logic [2:0] el, input int ptr, input logic [8:0] robs);
`ifdef RS_AGE_PRIO_EN
    int best = -1, bk = 0;
    for (int i = 0; i < 3; i++) begin
      int k;
      k = ((int'(robs >> (i * RW)) & 7) - int'(rob_head)) & 7;
      if (el[i] && (best < 0 || k < bk)) begin best = i; bk = k; end
    end
    return best;
`else
    for (int off = 0; off < 3; off++)
      if (el[(ptr + off) % 3]) return (ptr + off) % 3;
    return -1;
`endif
  endfunction

  // Compute the expected outputs for the coming edge, advance the model, then clock.
  task automatic tick();
    logic [2:0] ae, me;
    int ga = -1, gm = -1;
    bit mw, busy;
    if (rst) begin
      m_ptr_a = 0; m_ptr_m = 0; m_lost = 0; m_pv = 0; m_pu = 0; m_pi = 0;
      m_free_at = 0; m_last_mg = -1; exp_o = '0;
    end else begin
      for (int i = 0; i < 3; i++) begin
        ae[i] = add_rdy[i] && add_fu_free && !(m_pv && m_pu == 0 && m_pi == i);
        me[i] = mul_rdy[i] && (edge_n >= m_free_at) && !(m_pv && m_pu == 1 && m_pi == i);
      end
      mw = (me != 0) && (m_lost == SM || ae == 0);
      if (!flush) begin
        if (mw) gm = pick(me, m_ptr_m, mul_rob);
        else if (ae != 0) ga = pick(ae, m_ptr_a, add_rob);
      end
      if (flush || gm >= 0 || me == 0) m_lost = 0;
      else if (ga >= 0 && m_lost < SM) m_lost++;
      if (gm >= 0) begin
        m_free_at = edge_n + (mul_is_div[gm] ? DL : ML);
        m_last_mg = edge_n;
        m_ptr_m = (gm + 1) % 3;
      end
      if (ga >= 0) m_ptr_a = (ga + 1) % 3;
      m_pv = (ga >= 0) || (gm >= 0);
      m_pu = (gm >= 0) ? 1 : 0;
      m_pi = (gm >= 0) ? gm : ((ga >= 0) ? ga : 0);
      busy = (edge_n == m_last_mg) || (edge_n < m_free_at - 1);
      exp_o = {m_pv, (gm >= 0), 2'(m_pi), (ga >= 0) ? 3'(1 << ga) : 3'b000,
               (gm >= 0) ? 3'(1 << gm) : 3'b000, busy};
    end
    @(posedge clk1);
    edge_n++;
    #1;
  endtask

  task automatic set_idle();
    rst = 0; flush = 0; add_fu_free = 1; add_rdy = 0; mul_rdy = 0; mul_is_div = 0;
    add_rob = 0; mul_rob = 0; rob_head = 0;
  endtask

  task automatic do_reset();
    rst = 1;
    tick();
    checks++;
    if (obs !== exp_o) begin errors++; $display("FAIL reset_pulse obs=%b exp=%b", obs, exp_o); end
    rst = 0;
  endtask

  task automatic test_reset();
    set_idle();
    rst = 1; add_rdy = 3'b111; mul_rdy = 3'b111; flush = 1;
    for (int c = 0; c < 2; c++) begin
      tick();
      checks++;
      if (obs !== 11'b0) begin errors++; $display("FAIL reset_outputs cyc%0d obs=%b exp=0", c, obs); end
    end
    rst = 0; flush = 0; mul_rdy = 0;
  endtask

  task automatic test_rr_release();
    logic [2:0] want [4] = '{3'b001, 3'b010, 3'b100, 3'b001};
    add_rdy = 3'b111;
    for (int c = 0; c < 4; c++) begin
      tick();
      checks++;
      if (obs !== exp_o) begin errors++; $display("FAIL rr_model cyc%0d obs=%b exp=%b", c, obs, exp_o); end
      checks++;
      if (!iss_valid || add_clr !== want[c])
        begin errors++; $display("FAIL rr_order cyc%0d add_clr=%b exp=%b", c, add_clr, want[c]); end
    end
  endtask

  task automatic test_pend();
    bit prev = 0;
    set_idle();
    do_reset();
    add_rdy = 3'b001;
    for (int c = 0; c < 8; c++) begin
      tick();
      checks++;
      if (obs !== exp_o) begin errors++; $display("FAIL pend_model cyc%0d obs=%b exp=%b", c, obs, exp_o); end
      checks++;
      if (iss_valid === prev)
        begin errors++; $display("FAIL pend_alternate cyc%0d iss_valid=%b exp=%b", c, iss_valid, !prev); end
      prev = iss_valid;
    end
  endtask

  task automatic test_mul_occupancy();
    int last = -1;
    set_idle();
    do_reset();
    mul_rdy = 3'b011;
    for (int c = 0; c < 14; c++) begin
      tick();
      checks++;
      if (obs !== exp_o) begin errors++; $display("FAIL mul_model cyc%0d obs=%b exp=%b", c, obs, exp_o); end
      if (iss_valid && iss_unit) begin
        if (last >= 0) begin
          checks++;
          if (edge_n - last != ML)
            begin errors++; $display("FAIL mul_spacing gap=%0d exp=%0d", edge_n - last, ML); end
        end
        last = edge_n;
      end
    end
    mul_is_div = 3'b001;
    for (int c = 0; c < 24; c++) begin
      tick();
      checks++;
      if (obs !== exp_o) begin errors++; $display("FAIL div_model cyc%0d obs=%b exp=%b", c, obs, exp_o); end
    end
  endtask

  task automatic test_starvation();
    set_idle();
    do_reset();
    add_rdy = 3'b111; mul_rdy = 3'b001;
    for (int c = 0; c < 7; c++) begin
      tick();
      checks++;
      if (obs !== exp_o) begin errors++; $display("FAIL starve_model cyc%0d obs=%b exp=%b", c, obs, exp_o); end
      if (c < 4) begin
        checks++;
        if (!(iss_valid && !iss_unit))
          begin errors++; $display("FAIL starve_add cyc%0d unit=%b valid=%b exp add", c, iss_unit, iss_valid); end
      end else if (c == 4) begin
        checks++;
        if (!(iss_valid && iss_unit && mul_clr == 3'b001))
          begin errors++; $display("FAIL starve_mul valid=%b unit=%b mul_clr=%b exp 1 1 001", iss_valid, iss_unit, mul_clr); end
      end
    end
  endtask

  task automatic test_flush();
    set_idle();
    do_reset();
    mul_rdy = 3'b001;
    tick();
    checks++;
    if (obs !== exp_o) begin errors++; $display("FAIL flush_pre obs=%b exp=%b", obs, exp_o); end
    mul_rdy = 0; add_rdy = 3'b111; flush = 1;
    tick();
    checks++;
    if (iss_valid !== 1'b0 || add_clr !== 3'b0 || mul_busy !== 1'b1)
      begin errors++; $display("FAIL flush_kill valid=%b add_clr=%b busy=%b exp 0 000 1", iss_valid, add_clr, mul_busy); end
    flush = 0;
    for (int c = 0; c < 4; c++) begin
      tick();
      checks++;
      if (obs !== exp_o) begin errors++; $display("FAIL flush_post cyc%0d obs=%b exp=%b", c, obs, exp_o); end
    end
  endtask

  task automatic test_random();
    set_idle();
    do_reset();
    for (int c = 0; c < 500; c++) begin
      rst = ($urandom_range(0, 99) == 0);
      flush = ($urandom_range(0, 9) == 0);
      add_fu_free = ($urandom_range(0, 3) != 0);
      add_rdy = 3'($urandom); mul_rdy = 3'($urandom); mul_is_div = 3'($urandom);
      add_rob = 9'($urandom); mul_rob = 9'($urandom); rob_head = 3'($urandom);
      tick();
      checks++;
      if (obs !== exp_o) begin errors++; $display("FAIL random cyc%0d obs=%b exp=%b", c, obs, exp_o); end
    end
    set_idle();
  endtask

`ifdef RS_AGE_PRIO_EN
  task automatic test_age();
    set_idle();
    do_reset();
    rob_head = 3'd6; add_rob = {3'd0, 3'd7, 3'd5}; add_rdy = 3'b111;
    tick();
    checks++;
    if (!iss_valid || iss_idx !== 2'd1) begin errors++; $display("FAIL age_first idx=%0d exp=1", iss_idx); end
    tick();
    checks++;
    if (!iss_valid || iss_idx !== 2'd2) begin errors++; $display("FAIL age_second idx=%0d exp=2", iss_idx); end
  endtask
`endif

  initial begin
    set_idle();
    #2;
    test_reset();
    test_rr_release();
    test_pend();
    test_mul_occupancy();
    test_starvation();
    test_flush();
`ifdef RS_AGE_PRIO_EN
    test_age();
`endif
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
